usr_cmd_sequencer: RTL
======================

// Module: usr_cmd_sequencer
// PURPOSE
//  Upstream controller for the 4-bit universal shift register. Accepts one command per
//  valid/ready handshake and drives the register's MODE, P_in and S_in inputs cycle by cycle.
//  Supported operations: load-then-shift, load-then-rotate, and serial shift-in.
//  Sits between the command source (bus/host FSM) and the universal shift register.
// PARAMETERS
//  WIDTH   4  data width of the shift register; drives the P_in and cmd_data width
//  CNT_W   4  width of cmd_count; a single command issues at most 2**CNT_W-1 shift steps
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        sequencer can accept a command (high only in IDLE)
//  cmd_op     in   2        0 LD_SHR, 1 LD_SHL, 2 LD_ROT, 3 SER_IN
//  cmd_data   in   WIDTH    load word (LD_*) or serial bit source, LSB first (SER_IN)
//  cmd_count  in   CNT_W    number of shift/rotate steps
//  MODE       out  3        to shift reg: 0 hold, 1 shift right, 2 shift left, 3 load, 4 rotate right
//  P_in       out  WIDTH    to shift reg parallel input
//  S_in       out  1        to shift reg serial input
//  busy       out  1        command in progress (state != IDLE)
//  done       out  1        one-cycle pulse when a command completes
// BEHAVIOUR
//  - All outputs are registered except cmd_ready, which is combinational: cmd_ready = (state==IDLE).
//  - Reset values: MODE=0, P_in=0, S_in=0, busy=0, done=0, state=IDLE. After reset cmd_ready=1.
//  - FSM states: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
//  - Accept: on a clk edge with cmd_valid & cmd_ready, latch op, data and count. cmd_valid outside IDLE is ignored.
//  - LD_*: the cycle after accept is LOAD, with MODE=3 and P_in=cmd_data.
//    Then SHIFT for cmd_count cycles: MODE=1 (SHR), 2 (SHL) or 4 (ROT).
//    S_in=0 throughout LD_SHR/LD_SHL; shifted-in bits are zero.
//  - SER_IN: LOAD is skipped. SHIFT runs n=min(cmd_count,WIDTH) cycles with MODE=1.
//    On step i (0-based), S_in=cmd_data[i].
//  - cmd_count==0: SHIFT is skipped. LD_* goes LOAD->DONE; SER_IN goes IDLE->DONE.
//  - DONE lasts one cycle: MODE=0 and done=1. Next cycle: IDLE, cmd_ready=1.
//  - Latency from accept edge to done high:
//    LD_*: count+2 cycles. SER_IN: min(count,WIDTH)+1 cycles.
//  - P_in holds its last loaded value until the next LOAD; MODE=0 whenever in IDLE.
//  - The step counter is a down-counter loaded at accept. It does not wrap; SHIFT exits when it reaches 1.
//  - rst asserted mid-command: immediate return to IDLE with reset values; the command is dropped.
//    No done pulse is emitted for the dropped command.
//  - Back-to-back commands: the earliest next accept is the clk edge at which DONE->IDLE completes, plus one.
//    Hence minimum spacing is latency+1 cycles.
// STRUCTURE
//  - Shared package usr_pkg:
//    - MODE codes: MODE_HOLD=0, MODE_SHR=1, MODE_SHL=2, MODE_LOAD=3, MODE_ROT=4.
//    - cmd_op codes: OP_LD_SHR, OP_LD_SHL, OP_LD_ROT, OP_SER_IN.
//    - FSM state encoding.
//    - The universal shift register imports the same MODE codes.
//  - One sub-module, usr_step_counter: loadable CNT_W down-counter with load/en inputs and a last-step flag (cnt==1).
//  - Top level: FSM plus output registers.
// TESTING (bench instantiates usr_cmd_sequencer driving the universal shift register; checks MODE/P_in/S_in and parallel_Q)
//  1 Reset: rst=1 for 15 time units mid-clock -> all outputs 0, cmd_ready=1; release -> MODE stays 0.
//  2 LD_SHR data=4'b0111 count=2 -> one cycle MODE=3 P_in=0111, two cycles MODE=1.
//    Then done, parallel_Q=4'b0001. Latency 4.
//  3 LD_ROT data=4'b1001 count=5 -> five cycles MODE=4, parallel_Q=4'b1100, done after 7 cycles.
//  4 SER_IN data=4'b1011 count=6 (clipped to 4) -> S_in sequence 1,1,0,1 with MODE=1.
//    Then done, parallel_Q=4'b1011.
//  5 count=0 LD_SHL data=4'b0101 -> LOAD, then DONE immediately, parallel_Q=0101.
//    cmd_valid held high during busy -> no second accept.
//  6 rst pulsed during SHIFT of LD_SHL count=3 -> MODE=0, busy=0 asynchronously, no done pulse.
//    Next command is accepted normally.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its command sequencer.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHR  = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_LOAD = 3'd3;
    localparam logic [2:0] MODE_ROT  = 3'd4;

    typedef enum logic [1:0] {
        OP_LD_SHR = 2'd0,
        OP_LD_SHL = 2'd1,
        OP_LD_ROT = 2'd2,
        OP_SER_IN = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] shift_mode(input op_t op);
        case (op)
            OP_LD_SHL: shift_mode = MODE_SHL;
            OP_LD_ROT: shift_mode = MODE_ROT;
            default:   shift_mode = MODE_SHR;
        endcase
    endfunction

endpackage

// File: rtl/usr_step_counter.sv
// Loadable down-counter for shift steps; saturates at zero and flags the final step.
module usr_step_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_value;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer: turns one accepted command into a cycle-by-cycle MODE/P_in/S_in
// stream for the universal shift register. Outputs reflect the state just left.
module usr_cmd_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [2:0]       MODE,
    output logic [WIDTH-1:0] P_in,
    output logic             S_in,
    output logic             busy,
    output logic             done
);

    state_t           state_reg;
    op_t              op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] load_value;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             accept;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Serial shift-in can only consume WIDTH bits of cmd_data.
    always_comb begin
        load_value = cmd_count;
        if ((cmd_op == OP_SER_IN) && (32'(cmd_count) > WIDTH)) begin
            load_value = CNT_W'(WIDTH);
        end
    end

    usr_step_counter #(
        .CNT_W(CNT_W)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .en         (state_reg == ST_SHIFT),
        .load_value (load_value),
        .cnt        (cnt),
        .last       (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_LD_SHR;
            data_reg  <= '0;
            MODE      <= MODE_HOLD;
            P_in      <= '0;
            S_in      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            MODE <= MODE_HOLD;
            S_in <= 1'b0;
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg   <= op_t'(cmd_op);
                        data_reg <= cmd_data;
                        busy     <= 1'b1;
                        if (cmd_op != OP_SER_IN) begin
                            state_reg <= ST_LOAD;
                        end else if (load_value == '0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg <= ST_SHIFT;
                        end
                    end
                end
                ST_LOAD: begin
                    MODE      <= MODE_LOAD;
                    P_in      <= data_reg;
                    state_reg <= (cnt == '0) ? ST_DONE : ST_SHIFT;
                end
                ST_SHIFT: begin
                    MODE <= shift_mode(op_reg);
                    // Serial source is consumed LSB first by shifting the latched word.
                    if (op_reg == OP_SER_IN) begin
                        S_in     <= data_reg[0];
                        data_reg <= data_reg >> 1;
                    end
                    if (last) begin
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
